// File: rtl/sram_row_access_ctrl.sv
// Access sequencer feeding the SRAM row decoder: accepts one request at a time
// and walks precharge -> wordline -> (sense) -> done with registered strobes.
module sram_row_access_ctrl #(
  parameter int ADDR_BITS    = 6,
  parameter int PRE_CYCLES   = 1,
  parameter int WL_CYCLES    = 2,
  parameter int SENSE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic                 req_we,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 en,
  output logic                 pre_n,
  output logic                 we_en,
  output logic                 sae,
  output logic                 rsp_valid,
  output logic                 busy
);

  localparam int MAX_PW  = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
  localparam int MAX_CYC = (MAX_PW > SENSE_CYCLES) ? MAX_PW : SENSE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PRE_LOAD   = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WL_LOAD    = CNT_W'(WL_CYCLES - 1);
  localparam logic [CNT_W-1:0] SENSE_LOAD = CNT_W'(SENSE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WL,
    S_SENSE,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;

  // Every strobe is assigned on the transition into the state that owns it,
  // so the outputs are plain flops and never see req_* combinationally.
  // NOTE: all state here is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr      <= '0;
      en        <= 1'b0;
      pre_n     <= 1'b0;
      we_en     <= 1'b0;
      sae       <= 1'b0;
      rsp_valid <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr      <= req_addr;
            we_q      <= req_we;
            cnt_q     <= PRE_LOAD;
            state_q   <= S_PRE;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_PRE: begin
          if (cnt_q == '0) begin
            cnt_q   <= WL_LOAD;
            state_q <= S_WL;
            pre_n   <= 1'b1;
            en      <= 1'b1;
            we_en   <= we_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_WL: begin
          if (cnt_q == '0) begin
            en    <= 1'b0;
            we_en <= 1'b0;
            if (we_q) begin
              pre_n     <= 1'b0;
              rsp_valid <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              sae     <= 1'b1;
              cnt_q   <= SENSE_LOAD;
              state_q <= S_SENSE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_SENSE: begin
          if (cnt_q == '0) begin
            sae       <= 1'b0;
            pre_n     <= 1'b0;
            rsp_valid <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          en        <= 1'b0;
          we_en     <= 1'b0;
          sae       <= 1'b0;
          pre_n     <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_row_access_ctrl.sv
// Bench for sram_row_access_ctrl: two instances (default and 3/1/2 phase
// lengths) checked every cycle against a timeline model, plus directed tables.
module tb_sram_row_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic [5:0] req_addr = '0;
  logic       req_we = 1'b0;

  logic       req_ready_w [2];
  logic [5:0] addr_w      [2];
  logic       en_w        [2];
  logic       pre_n_w     [2];
  logic       we_en_w     [2];
  logic       sae_w       [2];
  logic       rsp_w       [2];
  logic       busy_w      [2];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_row_access_ctrl #(.ADDR_BITS(6)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_w[0]),
    .req_addr(req_addr), .req_we(req_we), .addr(addr_w[0]), .en(en_w[0]),
    .pre_n(pre_n_w[0]), .we_en(we_en_w[0]), .sae(sae_w[0]),
    .rsp_valid(rsp_w[0]), .busy(busy_w[0])
  );

  sram_row_access_ctrl #(.ADDR_BITS(6), .PRE_CYCLES(3), .WL_CYCLES(1), .SENSE_CYCLES(2)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_w[1]),
    .req_addr(req_addr), .req_we(req_we), .addr(addr_w[1]), .en(en_w[1]),
    .pre_n(pre_n_w[1]), .we_en(we_en_w[1]), .sae(sae_w[1]),
    .rsp_valid(rsp_w[1]), .busy(busy_w[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  int   p_c [2] = '{1, 3};
  int   w_c [2] = '{2, 1};
  int   s_c [2] = '{1, 2};
  int   cyc = 0;
  int   acc [2] = '{0, 0};
  bit   active [2] = '{1'b0, 1'b0};
  bit   m_we [2] = '{1'b0, 1'b0};
  logic [5:0] m_addr [2] = '{6'd0, 6'd0};

  // Edge index (relative to the accept edge) on which rsp_valid is high.
  function automatic int len_of(input int i);
    return p_c[i] + w_c[i] + (m_we[i] ? 0 : s_c[i]);
  endfunction

  function automatic bit model_idle(input int i, input int c);
    return !active[i] || ((c - acc[i]) > len_of(i));
  endfunction

  function automatic logic [31:0] pack(input bit rdy, input bit bsy, input bit rsp, input bit pre,
                                       input bit e, input bit we, input bit sa, input logic [5:0] a);
    return {19'b0, rdy, bsy, rsp, pre, e, we, sa, a};
  endfunction

  function automatic logic [31:0] exp_vec(input int i);
    int k;
    int l;
    if (!rst_n) return pack(1, 0, 0, 0, 0, 0, 0, 6'd0);
    k = cyc - acc[i];
    l = len_of(i);
    if (!active[i] || k > l)    return pack(1, 0, 0, 0, 0, 0, 0, m_addr[i]);
    if (k < p_c[i])             return pack(0, 1, 0, 0, 0, 0, 0, m_addr[i]);
    if (k < p_c[i] + w_c[i])    return pack(0, 1, 0, 1, 1, m_we[i], 0, m_addr[i]);
    if (k < l)                  return pack(0, 1, 0, 1, 0, 0, 1, m_addr[i]);
    return pack(0, 1, 1, 0, 0, 0, 0, m_addr[i]);
  endfunction

  function automatic logic [31:0] act_vec(input int i);
    return pack(req_ready_w[i], busy_w[i], rsp_w[i], pre_n_w[i], en_w[i], we_en_w[i], sae_w[i], addr_w[i]);
  endfunction

  function automatic logic [5:0] sig6(input int i);
    return {req_ready_w[i], rsp_w[i], pre_n_w[i], en_w[i], we_en_w[i], sae_w[i]};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        active[i] <= 1'b0;
        m_addr[i] <= '0;
      end else if (req_valid && model_idle(i, cyc)) begin
        active[i] <= 1'b1;
        acc[i]    <= cyc + 1;
        m_addr[i] <= req_addr;
        m_we[i]   <= req_we;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [5:0] prev_addr [2] = '{6'd0, 6'd0};
  bit         prev_ready [2] = '{1'b1, 1'b1};
  bit         prev_rst = 1'b0;
  bit         prev_en0 = 1'b0;
  bit         sweep_on = 1'b0;
  int         en_cnt = 0;
  logic [5:0] en_addr_q [$];
  int         rsp_cyc_q [$];

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d_outs_cyc%0d", i, cyc), act_vec(i), exp_vec(i));
        check($sformatf("u%0d_invariants_cyc%0d", i, cyc),
              {29'b0, en_w[i] & ~pre_n_w[i], en_w[i] & sae_w[i], we_en_w[i] & ~en_w[i]}, 32'h0);
        if (rst_n && prev_rst && addr_w[i] != prev_addr[i])
          check($sformatf("u%0d_addr_change_cyc%0d", i, cyc),
                {29'b0, prev_ready[i], en_w[i], sae_w[i]}, 32'h4);
        prev_addr[i]  <= addr_w[i];
        prev_ready[i] <= req_ready_w[i];
      end
      if (sweep_on) begin
        if (en_w[0]) en_cnt <= en_cnt + 1;
        if (en_w[0] && !prev_en0) en_addr_q.push_back(addr_w[0]);
        if (rsp_w[0]) rsp_cyc_q.push_back(cyc);
      end
      prev_en0 <= en_w[0];
      prev_rst <= rst_n;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_req(input logic [5:0] a, input logic we);
    req_addr  = a;
    req_we    = we;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req_ready_w[0] && req_ready_w[1]) && n < 50);
    if (n >= 50) check("wait_idle_timeout", n, 0);
  endtask

  task automatic count_rsp(input int n, output int cnt);
    cnt = 0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (rsp_w[0]) cnt++;
    end
  endtask

  // {ready, rsp, pre_n, en, we_en, sae} after each edge, accept edge first
  logic [5:0] t_rd37 [6] = '{6'b000000, 6'b001100, 6'b001100, 6'b001001, 6'b010000, 6'b100000};
  logic [5:0] t_wr63 [5] = '{6'b000000, 6'b001110, 6'b001110, 6'b010000, 6'b100000};
  logic [5:0] t_p312 [8] = '{6'b000000, 6'b000000, 6'b000000, 6'b001100,
                             6'b001001, 6'b001001, 6'b010000, 6'b100000};

  initial begin
    int cnt;
    int errs;
    int n;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready_busy", {30'b0, req_ready_w[0], busy_w[0]}, 32'h2);
    check("reset_strobes", {26'b0, addr_w[0] == 6'd0, pre_n_w[0], en_w[0], we_en_w[0], sae_w[0], rsp_w[0]}, 32'h20);

    // Read of row 37 on the default instance
    do_req(6'd37, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) check("rd37_addr", addr_w[0], 6'd37);
      check($sformatf("rd37_edge%0d", k), sig6(0), t_rd37[k]);
    end
    wait_idle();

    // Write of the top row
    do_req(6'd63, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("wr63_edge%0d", k), sig6(0), t_wr63[k]);
    end
    check("wr63_addr_held", addr_w[0], 6'd63);
    wait_idle();

    // Read of row 0 on the 3/1/2 instance
    do_req(6'd0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("p312_edge%0d", k), sig6(1), t_p312[k]);
    end
    wait_idle();

    // Request while busy is dropped
    do_req(6'd12, 1'b0);
    @(negedge clk);
    do_req(6'd5, 1'b0);
    count_rsp(12, cnt);
    check("busy_drop_rsp_count", cnt, 1);
    check("busy_drop_addr", addr_w[0], 6'd12);
    wait_idle();

    // Back-to-back writes sweeping every row with req_valid held high
    en_cnt = 0;
    en_addr_q.delete();
    rsp_cyc_q.delete();
    sweep_on  = 1'b1;
    req_we    = 1'b1;
    req_valid = 1'b1;
    for (int a = 0; a < 64; a++) begin
      req_addr = 6'(a);
      n = 0;
      while (!req_ready_w[0] && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) check("sweep_ready_timeout", n, 0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    sweep_on = 1'b0;
    check("sweep_en_cycles", en_cnt, 128);
    check("sweep_en_bursts", en_addr_q.size(), 64);
    check("sweep_rsp_pulses", rsp_cyc_q.size(), 64);
    errs = 0;
    foreach (en_addr_q[j]) if (en_addr_q[j] != 6'(j)) errs++;
    check("sweep_addr_sequence_errs", errs, 0);
    errs = 0;
    for (int j = 1; j < rsp_cyc_q.size(); j++) if (rsp_cyc_q[j] - rsp_cyc_q[j-1] != 5) errs++;
    check("sweep_accept_period_errs", errs, 0);
    wait_idle();

    // Reset during the wordline phase of a read of row 20
    do_req(6'd20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_wl_en_before", {31'b0, en_w[0]}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_async_strobes", {27'b0, rsp_w[0], pre_n_w[0], en_w[0], we_en_w[0], sae_w[0]}, 32'h0);
    check("rst_mid_async_ready", {31'b0, req_ready_w[0]}, 32'h1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    count_rsp(10, cnt);
    check("rst_mid_no_rsp", cnt, 0);
    check("rst_mid_idle", {30'b0, req_ready_w[0], busy_w[0]}, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
